// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and a variable-latency memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through, runs LOAD/STORE on a
// req/ack data memory with a timeout, and presents a registered write-back bundle.
module mem_stage #(
    parameter int MAX_WAIT = 200,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [4:0]  control_in,
    input  logic [15:0] result_in,
    input  logic [15:0] store_data,
    input  logic [5:0]  dest_index_in,
    input  logic        write_enable_in,
    output logic        stall,
    mem_stage_if.master mem,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [5:0]  wb_index,
    output logic [15:0] wb_data,
    output logic [4:0]  control_out,
    output logic        mem_error
);
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1110;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [15:0]       mem_addr_reg, mem_addr_next;
    logic [15:0]       mem_wdata_reg, mem_wdata_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [4:0]        ctrl_lat_reg, ctrl_lat_next;
    logic [5:0]        idx_lat_reg, idx_lat_next;
    logic              wb_valid_reg, wb_valid_next;
    logic              wb_en_reg, wb_en_next;
    logic [5:0]        wb_index_reg, wb_index_next;
    logic [15:0]       wb_data_reg, wb_data_next;
    logic [4:0]        control_out_reg, control_out_next;
    logic              mem_error_reg, mem_error_next;

    logic [3:0] opcode;
    logic       is_mem;
    logic       is_nop;
    logic       timeout;

    assign opcode  = control_in[3:0];
    assign is_mem  = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign is_nop  = (opcode == OP_NOP);
    assign timeout = (state_reg == ACCESS) && (wait_cnt_reg == WAIT_LAST) && !mem.mem_ack;

    // Held low during reset so upstream never freezes on a half-reset state.
    assign stall = !reset &&
                   (((state_reg == IDLE) && valid_in && is_mem) ||
                    ((state_reg == ACCESS) && !mem.mem_ack && !timeout));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
            wait_cnt_reg    <= '0;
            ctrl_lat_reg    <= '0;
            idx_lat_reg     <= '0;
            wb_valid_reg    <= 1'b0;
            wb_en_reg       <= 1'b0;
            wb_index_reg    <= '0;
            wb_data_reg     <= '0;
            control_out_reg <= '0;
            mem_error_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_req_reg     <= mem_req_next;
            mem_we_reg      <= mem_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            wait_cnt_reg    <= wait_cnt_next;
            ctrl_lat_reg    <= ctrl_lat_next;
            idx_lat_reg     <= idx_lat_next;
            wb_valid_reg    <= wb_valid_next;
            wb_en_reg       <= wb_en_next;
            wb_index_reg    <= wb_index_next;
            wb_data_reg     <= wb_data_next;
            control_out_reg <= control_out_next;
            mem_error_reg   <= mem_error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_in && is_mem) state_next = ACCESS;
            ACCESS:  if (mem.mem_ack || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req_next     = mem_req_reg;
        mem_we_next      = mem_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        wait_cnt_next    = wait_cnt_reg;
        ctrl_lat_next    = ctrl_lat_reg;
        idx_lat_next     = idx_lat_reg;
        wb_valid_next    = 1'b0;
        wb_en_next       = 1'b0;
        wb_index_next    = wb_index_reg;
        wb_data_next     = wb_data_reg;
        control_out_next = control_out_reg;
        mem_error_next   = mem_error_reg;
        case (state_reg)
            IDLE: begin
                if (valid_in && is_mem) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = (opcode == OP_STORE);
                    mem_addr_next  = result_in;
                    mem_wdata_next = store_data;
                    wait_cnt_next  = '0;
                    ctrl_lat_next  = control_in;
                    idx_lat_next   = dest_index_in;
                end else if (valid_in) begin
                    wb_valid_next    = 1'b1;
                    wb_en_next       = write_enable_in && !is_nop;
                    wb_index_next    = dest_index_in;
                    wb_data_next     = result_in;
                    control_out_next = control_in;
                end
            end
            ACCESS: begin
                if (mem.mem_ack) begin
                    mem_req_next     = 1'b0;
                    wb_valid_next    = 1'b1;
                    wb_en_next       = !mem_we_reg;
                    wb_index_next    = idx_lat_reg;
                    wb_data_next     = mem_we_reg ? mem_addr_reg : mem.mem_rdata;
                    control_out_next = ctrl_lat_reg;
                end else if (timeout) begin
                    // Retire as a bubble so the pipeline keeps its one-out-per-in accounting.
                    mem_req_next     = 1'b0;
                    mem_error_next   = 1'b1;
                    wb_valid_next    = 1'b1;
                    wb_index_next    = idx_lat_reg;
                    control_out_next = ctrl_lat_reg;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign wb_valid      = wb_valid_reg;
    assign wb_en         = wb_en_reg;
    assign wb_index      = wb_index_reg;
    assign wb_data       = wb_data_reg;
    assign control_out   = control_out_reg;
    assign mem_error     = mem_error_reg;
endmodule
